// File: rtl/qspi_host.sv
`default_nettype none
// ============================================================================
// qspi_host : QSPI initiator, 4-bit cmd/dummy/payload frames, SPI mode 0
// Revision  : 1.0
// ============================================================================
module qspi_host #(
    parameter int CLK_DIV      = 2,
    parameter int DUMMY_CYCLES = 2,
    parameter int CS_HOLD      = 2,
    parameter int LEN_W        = 16
) (
    input  logic             clk,
    input  logic             async_nreset,
    input  logic             start,
    input  logic [7:0]       cmd,
    input  logic             rd,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             qspi_clk,
    output logic             qspi_ncs,
    output logic [3:0]       qspi_io_out,
    output logic [3:0]       qspi_io_oe,
    input  logic [3:0]       qspi_io_in
);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int DUM_W  = $clog2(DUMMY_CYCLES + 1);
    localparam int HOLD_W = $clog2(CS_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_DUMMY = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t            state, state_nx;
    logic [DIV_W-1:0]  div_cnt;
    logic [DUM_W-1:0]  dum_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [LEN_W-1:0]  cnt;
    logic              rd_lat, nib, stall, have_byte;
    logic [7:0]        tx_buf;
    logic [3:0]        lo_nib, rx_hi;

    logic              active, phase_end, rise, fall, need_byte, take, byte_ok;
    logic              dum_last, hold_last;
    logic [7:0]        byte_in;

    always_comb begin
        active    = (state == S_CMD) || (state == S_DUMMY) || (state == S_READ) || (state == S_WRITE);
        phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));
        rise      = active && !stall && phase_end && !qspi_clk;
        fall      = active && !stall && phase_end && qspi_clk;
        // A byte is wanted during the final high phase of the current byte, or while stalled.
        need_byte = ((state == S_CMD) || (state == S_WRITE)) && nib && !rd_lat && (cnt != '0);
        tx_ready  = need_byte && (qspi_clk || stall) && !have_byte;
        take      = tx_valid && tx_ready;
        byte_ok   = have_byte || take;
        byte_in   = have_byte ? tx_buf : tx_data;
        dum_last  = (dum_cnt == DUM_W'(DUMMY_CYCLES - 1));
        hold_last = (hold_cnt == HOLD_W'(CS_HOLD - 1));
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) state <= S_IDLE;
        else               state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CMD;
            S_CMD:   if (fall && nib) state_nx = (cnt == '0) ? S_HOLD : (rd_lat ? S_DUMMY : S_WRITE);
            S_DUMMY: if (fall && dum_last) state_nx = S_READ;
            S_READ:  if (fall && nib && (cnt == LEN_W'(1))) state_nx = S_HOLD;
            S_WRITE: if (fall && nib && (cnt == '0)) state_nx = S_HOLD;
            S_HOLD:  if (hold_last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            qspi_ncs    <= 1'b1;
            qspi_clk    <= 1'b0;
            qspi_io_oe  <= 4'h0;
            qspi_io_out <= 4'h0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= 8'h00;
            rx_hi       <= 4'h0;
            lo_nib      <= 4'h0;
            tx_buf      <= 8'h00;
            have_byte   <= 1'b0;
            stall       <= 1'b0;
            nib         <= 1'b0;
            rd_lat      <= 1'b0;
            cnt         <= '0;
            div_cnt     <= '0;
            dum_cnt     <= '0;
            hold_cnt    <= '0;
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;
            if (take) begin
                tx_buf    <= tx_data;
                have_byte <= 1'b1;
            end
            if (state == S_IDLE) begin
                dum_cnt  <= '0;
                hold_cnt <= '0;
                if (start) begin
                    qspi_ncs    <= 1'b0;
                    busy        <= 1'b1;
                    qspi_io_oe  <= 4'hF;
                    qspi_io_out <= cmd[7:4];
                    lo_nib      <= cmd[3:0];
                    rd_lat      <= rd;
                    cnt         <= len;
                    nib         <= 1'b0;
                    div_cnt     <= '0;
                    qspi_clk    <= 1'b0;
                    stall       <= 1'b0;
                    have_byte   <= 1'b0;
                end
            end else if (state == S_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_last) begin
                    qspi_ncs   <= 1'b1;
                    qspi_io_oe <= 4'h0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                end
            end else if (stall) begin
                // sck parked low, io held; the new byte's low phase begins next cycle.
                if (take) begin
                    qspi_io_out <= tx_data[7:4];
                    lo_nib      <= tx_data[3:0];
                    cnt         <= cnt - LEN_W'(1);
                    nib         <= 1'b0;
                    div_cnt     <= '0;
                    stall       <= 1'b0;
                    have_byte   <= 1'b0;
                end
            end else begin
                div_cnt <= phase_end ? '0 : div_cnt + 1'b1;
                if (rise) begin
                    qspi_clk <= 1'b1;
                    if (state == S_READ) begin
                        if (!nib) begin
                            rx_hi <= qspi_io_in;
                        end else begin
                            rx_data  <= {rx_hi, qspi_io_in};
                            rx_valid <= 1'b1;
                        end
                    end
                end
                if (fall) begin
                    qspi_clk <= 1'b0;
                    case (state)
                        S_DUMMY: dum_cnt <= dum_cnt + 1'b1;
                        S_READ: begin
                            nib <= ~nib;
                            if (nib) cnt <= cnt - LEN_W'(1);
                        end
                        default: begin
                            if (!nib) begin
                                qspi_io_out <= lo_nib;
                                nib         <= 1'b1;
                            end else if (cnt != '0) begin
                                if (rd_lat) begin
                                    qspi_io_oe <= 4'h0;
                                    nib        <= 1'b0;
                                end else if (byte_ok) begin
                                    qspi_io_out <= byte_in[7:4];
                                    lo_nib      <= byte_in[3:0];
                                    cnt         <= cnt - LEN_W'(1);
                                    nib         <= 1'b0;
                                    have_byte   <= 1'b0;
                                end else begin
                                    stall <= 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule
`default_nettype wire
